// File: rtl/debouncer_array_pkg.sv
// debouncer_array_pkg: shared FSM state type and timing helpers for the debouncer array
// Build option: define DEBOUNCER_ARRAY_SYNC_EN to put a 2-flop synchroniser on each switch input.
package debouncer_array_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } db_state_e;

   function automatic int stable_cycles(input int clk_freq, input int stable_time_ms);
      return clk_freq / 1000 * stable_time_ms;
   endfunction

   function automatic int cnt_width(input int cycles);
      return $clog2(cycles);
   endfunction

endpackage

// File: rtl/debouncer_ch.sv
// debouncer_ch: one debounce channel (input sampling, stability counter, FSM, edge ticks)
// Build option: DEBOUNCER_ARRAY_SYNC_EN selects a 2-flop synchroniser instead of a single sample flop.
module debouncer_ch
   import debouncer_array_pkg::*;
#(
   parameter int StableCycles = 10,
   parameter int CntW         = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic sw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [CntW-1:0] Last = CntW'(StableCycles - 1);

   logic            sample;
   db_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            rise, fall;

`ifdef DEBOUNCER_ARRAY_SYNC_EN
   logic [1:0] sync_q;

   // two-stage synchroniser on the raw switch input
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= {sync_q[0], sw_i};
   end

   assign sample = sync_q[1];
`else
   logic sample_q;

   // single sampling register on the raw switch input
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sample_q <= 1'b0;
      else         sample_q <= sw_i;
   end

   assign sample = sample_q;
`endif

   // FSM state and stability counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state: qualify a candidate level; abort on revert or disable, tick on the completing cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise    = 1'b0;
      fall    = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            cnt_d = '0;
            if (en_i && sample) state_d = WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (!en_i || !sample) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == Last) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
               rise    = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         end
         IDLE_HIGH: begin
            cnt_d = '0;
            if (en_i && !sample) state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!en_i || sample) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == Last) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
               fall    = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // the level flips in the completing cycle together with its tick, then the new IDLE state holds it
   assign level_o = ((state_q == IDLE_HIGH) || (state_q == WAIT_LOW)) ^ (rise | fall);
   assign rise_o  = rise;
   assign fall_o  = fall;

endmodule

// File: rtl/debouncer_array.sv
// debouncer_array: NumCh independent switch debouncers with per-channel edge ticks and a combined tick
// Build option: DEBOUNCER_ARRAY_SYNC_EN adds a 2-flop input synchroniser per channel (one extra cycle of latency).
module debouncer_array
   import debouncer_array_pkg::*;
#(
   parameter int NumCh        = 8,
   parameter int ClkFreq      = 100_000_000,
   parameter int StableTimeMs = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [NumCh-1:0] sw_i,
   output logic [NumCh-1:0] db_level_o,
   output logic [NumCh-1:0] rise_tick_o,
   output logic [NumCh-1:0] fall_tick_o,
   output logic             any_tick_o
);

   localparam int StableCycles = stable_cycles(ClkFreq, StableTimeMs);
   localparam int CntW         = cnt_width(StableCycles);

   for (genvar i = 0; i < NumCh; i++) begin : g_ch
      debouncer_ch #(
         .StableCycles(StableCycles),
         .CntW        (CntW)
      ) u_ch (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .en_i   (en_i),
         .sw_i   (sw_i[i]),
         .level_o(db_level_o[i]),
         .rise_o (rise_tick_o[i]),
         .fall_o (fall_tick_o[i])
      );
   end

   assign any_tick_o = |(rise_tick_o | fall_tick_o);

endmodule

// File: tb/tb_debouncer_array.sv
// tb_debouncer_array: directed checks of debounce latency, bounce rejection, enable abort and async reset
module tb_debouncer_array;

   localparam int NumCh = 4;
`ifdef DEBOUNCER_ARRAY_SYNC_EN
   localparam int Lat = 12;
`else
   localparam int Lat = 11;
`endif

   logic             clk = 1'b0;
   logic             rst_ni = 1'b0;
   logic             en_i = 1'b1;
   logic [NumCh-1:0] sw_i = '0;
   logic [NumCh-1:0] db_level_o, rise_tick_o, fall_tick_o;
   logic             any_tick_o;
   int               n_cmp = 0;
   int               n_err = 0;

   debouncer_array #(
      .NumCh       (NumCh),
      .ClkFreq     (10_000),
      .StableTimeMs(1)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .en_i       (en_i),
      .sw_i       (sw_i),
      .db_level_o (db_level_o),
      .rise_tick_o(rise_tick_o),
      .fall_tick_o(fall_tick_o),
      .any_tick_o (any_tick_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [NumCh-1:0] obs, input logic [NumCh-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic go(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [NumCh-1:0] lvl, input logic [NumCh-1:0] r,
                          input logic [NumCh-1:0] f, input logic a);
      chk({tag, ".level"}, db_level_o, lvl);
      chk({tag, ".rise"}, rise_tick_o, r);
      chk({tag, ".fall"}, fall_tick_o, f);
      chk({tag, ".any"}, NumCh'(any_tick_o), NumCh'(a));
   endtask

   initial begin
      go(3);
      chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      rst_ni = 1'b1;
      go(2);
      chk_all("post_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      // channel 0 rises after exactly Lat cycles
      sw_i = 4'b0001;
      go(Lat - 1);
      chk_all("rise0_early", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      go(1);
      chk_all("rise0_tick", 4'b0001, 4'b0001, 4'b0000, 1'b1);
      go(1);
      chk_all("rise0_after", 4'b0001, 4'b0000, 4'b0000, 1'b0);
      // channel 1 bounces with 5-cycle half period: never qualifies
      for (int t = 0; t < 20; t++) begin
         sw_i[1] = ~sw_i[1];
         for (int c = 0; c < 5; c++) begin
            go(1);
            chk("bounce_any", NumCh'(any_tick_o), 4'b0000);
         end
      end
      chk("bounce_level", db_level_o, 4'b0001);
      go(Lat + 2);
      chk_all("bounce_settle", 4'b0001, 4'b0000, 4'b0000, 1'b0);
      // channels 2 and 3 rise together
      sw_i = 4'b1101;
      go(Lat - 1);
      chk_all("rise23_early", 4'b0001, 4'b0000, 4'b0000, 1'b0);
      go(1);
      chk_all("rise23_tick", 4'b1101, 4'b1100, 4'b0000, 1'b1);
      go(1);
      chk_all("rise23_after", 4'b1101, 4'b0000, 4'b0000, 1'b0);
      // channel 0 falls
      sw_i = 4'b1100;
      go(Lat - 1);
      chk_all("fall0_early", 4'b1101, 4'b0000, 4'b0000, 1'b0);
      go(1);
      chk_all("fall0_tick", 4'b1100, 4'b0000, 4'b0001, 1'b1);
      go(1);
      chk_all("fall0_after", 4'b1100, 4'b0000, 4'b0000, 1'b0);
      // channel 1 rise, disabled at counter=5, then requalifies from zero
      sw_i = 4'b1110;
      go(Lat - 4);
      en_i = 1'b0;
      for (int c = 0; c < 20; c++) begin
         go(1);
         chk("dis_any", NumCh'(any_tick_o), 4'b0000);
      end
      chk("dis_level", db_level_o, 4'b1100);
      en_i = 1'b1;
      go(9);
      chk_all("reen_early", 4'b1100, 4'b0000, 4'b0000, 1'b0);
      go(1);
      chk_all("reen_tick", 4'b1110, 4'b0010, 4'b0000, 1'b1);
      go(1);
      chk_all("reen_after", 4'b1110, 4'b0000, 4'b0000, 1'b0);
      // channel 1 fall aborted by en_i dropping in the completing cycle
      sw_i = 4'b1100;
      go(Lat);
      en_i = 1'b0;
      #1;
      chk_all("abort_tick", 4'b1110, 4'b0000, 4'b0000, 1'b0);
      go(1);
      chk_all("abort_hold", 4'b1110, 4'b0000, 4'b0000, 1'b0);
      en_i = 1'b1;
      go(9);
      chk_all("abort_requal_early", 4'b1110, 4'b0000, 4'b0000, 1'b0);
      go(1);
      chk_all("abort_requal_tick", 4'b1100, 4'b0000, 4'b0010, 1'b1);
      go(1);
      chk_all("abort_requal_after", 4'b1100, 4'b0000, 4'b0000, 1'b0);
      // asynchronous reset in the middle of a qualification
      sw_i = 4'b1111;
      go(5);
      rst_ni = 1'b0;
      #1;
      chk_all("async_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      go(3);
      chk_all("rst_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      rst_ni = 1'b1;
      for (int c = 0; c < Lat - 1; c++) begin
         go(1);
         chk("rst_requal_any", NumCh'(any_tick_o), 4'b0000);
      end
      chk("rst_requal_level", db_level_o, 4'b0000);
      go(1);
      chk_all("rst_requal_tick", 4'b1111, 4'b1111, 4'b0000, 1'b1);
      go(1);
      chk_all("rst_requal_after", 4'b1111, 4'b0000, 4'b0000, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
